// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - bit-rate codes, nominal start-bit periods and autobaud state encoding
package uart_pkg;

    localparam logic [3:0] BR_2400    = 4'h1;
    localparam logic [3:0] BR_4800    = 4'h2;
    localparam logic [3:0] BR_9600    = 4'h3;
    localparam logic [3:0] BR_19200   = 4'h4;
    localparam logic [3:0] BR_38400   = 4'h5;
    localparam logic [3:0] BR_57600   = 4'h6;
    localparam logic [3:0] BR_115200  = 4'h7;
    localparam logic [3:0] BR_230400  = 4'h8;
    localparam logic [3:0] BR_460800  = 4'h9;
    localparam logic [3:0] BR_921600  = 4'ha;
    localparam logic [3:0] BR_6M25    = 4'hf;
    localparam logic [3:0] BR_DEFAULT = BR_9600;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_FALL,
        S_MEASURE,
        S_CLASSIFY,
        S_VERIFY,
        S_LOCK,
        S_FAIL
    } abState_t;

    // Bit period in F50Clk cycles for each code; 0 marks an unused code.
    function automatic logic [15:0] nominalPeriod(input logic [3:0] code);
        case (code)
            BR_2400:   return 16'd20833;
            BR_4800:   return 16'd10417;
            BR_9600:   return 16'd5208;
            BR_19200:  return 16'd2604;
            BR_38400:  return 16'd1302;
            BR_57600:  return 16'd868;
            BR_115200: return 16'd434;
            BR_230400: return 16'd217;
            BR_460800: return 16'd108;
            BR_921600: return 16'd54;
            BR_6M25:   return 16'd8;
            default:   return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_autobaud_classify.sv
// rtl/uart_autobaud_classify.sv - combinational start-bit width to bit-rate code matcher
module uart_autobaud_classify
    import uart_pkg::*;
(
    input  logic [15:0] width,
    output logic [3:0]  code,
    output logic        hit
);

    // Tolerance is nominal/8 either side; the windows never overlap.
    function automatic logic inWindow(input logic [15:0] w, input logic [15:0] nom);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, nom} - {4'b0, nom[15:3]};
        hi = {1'b0, nom} + {4'b0, nom[15:3]};
        return (nom != 16'd0) && ({1'b0, w} >= lo) && ({1'b0, w} <= hi);
    endfunction

    // Scan every code; at most one window can contain the width.
    always_comb begin
        code = BR_DEFAULT;
        hit  = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (inWindow(width, nominalPeriod(4'(i)))) begin
                code = 4'(i);
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// rtl/uart_autobaud_ctrl.sv - start-bit autobaud controller driving BitRateSel (option AUTOBAUD_VERIFY_EN)
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] IDLE_CYCLES = 16'd2000,
    parameter int          SYNC_STAGES = 2
)(
    input  logic       F50Clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       start,
    input  logic       manual_mode,
    input  logic [3:0] manual_sel,
    output logic [3:0] BitRateSel,
    output logic       busy,
    output logic       locked,
    output logic       error
);

    logic [SYNC_STAGES-1:0] rxdSync;
    logic                   rxdS;
    logic                   rxdD;
    logic                   fallEdge;
    logic                   riseEdge;
    abState_t               state;
    abState_t               nextState;
    logic [15:0]            cnt;
    logic [15:0]            idleCnt;
    logic [3:0]             detCode;
    logic [3:0]             clsCode;
    logic                   clsHit;
    logic                   enterLock;
`ifdef AUTOBAUD_VERIFY_EN
    logic [3:0]             firstCode;
    logic                   secondPass;
`endif

    assign rxdS      = rxdSync[SYNC_STAGES-1];
    assign fallEdge  = rxdD & ~rxdS;
    assign riseEdge  = ~rxdD & rxdS;
    assign enterLock = (nextState == S_LOCK) && (state != S_LOCK);

    // The measured width is held in cnt while CLASSIFY evaluates it.
    uart_autobaud_classify uClassify (
        .width (cnt),
        .code  (clsCode),
        .hit   (clsHit)
    );

    // Synchronizer chain plus delayed copy; preset high so reset never looks like a start bit.
    always_ff @(posedge F50Clk or negedge reset_n) begin
        if (!reset_n) begin
            rxdSync <= '1;
            rxdD    <= 1'b1;
        end else begin
            rxdSync <= {rxdSync[SYNC_STAGES-2:0], rxd};
            rxdD    <= rxdS;
        end
    end

    // State register.
    always_ff @(posedge F50Clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nextState;
    end

    // Next-state logic; start overrides everything, including a coincident rising edge.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: ;
            S_WAIT_IDLE: if (rxdS && idleCnt == IDLE_CYCLES - 16'd1) nextState = S_WAIT_FALL;
            S_WAIT_FALL: if (fallEdge) nextState = S_MEASURE;
            S_MEASURE: begin
                if (riseEdge)                         nextState = S_CLASSIFY;
                else if (!rxdS && cnt == 16'hFFFF)   nextState = S_FAIL;
            end
`ifdef AUTOBAUD_VERIFY_EN
            S_CLASSIFY: begin
                if (!clsHit)                     nextState = S_FAIL;
                else if (!secondPass)            nextState = S_VERIFY;
                else if (clsCode == firstCode)   nextState = S_LOCK;
                else                             nextState = S_FAIL;
            end
            S_VERIFY: nextState = S_WAIT_FALL;
`else
            S_CLASSIFY: nextState = clsHit ? S_LOCK : S_FAIL;
`endif
            S_LOCK: ;
            S_FAIL: ;
            default: nextState = S_IDLE;
        endcase
        if (start) nextState = S_WAIT_IDLE;
    end

    // Idle-high run counter and start-bit width counter.
    always_ff @(posedge F50Clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 16'd0;
            idleCnt <= 16'd0;
        end else if (start) begin
            cnt     <= 16'd0;
            idleCnt <= 16'd0;
        end else begin
            case (state)
                S_WAIT_IDLE: idleCnt <= rxdS ? idleCnt + 16'd1 : 16'd0;
                S_WAIT_FALL: if (fallEdge) cnt <= 16'd1;
                S_MEASURE:   if (!rxdS && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
                default: ;
            endcase
        end
    end

`ifdef AUTOBAUD_VERIFY_EN
    // First-pass code remembered for comparison against the second pulse.
    always_ff @(posedge F50Clk or negedge reset_n) begin
        if (!reset_n) begin
            firstCode  <= BR_DEFAULT;
            secondPass <= 1'b0;
        end else if (start) begin
            secondPass <= 1'b0;
        end else if (state == S_CLASSIFY && nextState == S_VERIFY) begin
            firstCode  <= clsCode;
            secondPass <= 1'b1;
        end
    end
`endif

    // Detected code and generator select; BitRateSel moves only on lock or manual override.
    always_ff @(posedge F50Clk or negedge reset_n) begin
        if (!reset_n) begin
            detCode    <= BR_DEFAULT;
            BitRateSel <= BR_DEFAULT;
        end else begin
            if (enterLock) detCode <= clsCode;
            if (manual_mode)    BitRateSel <= manual_sel;
            else if (enterLock) BitRateSel <= clsCode;
            else                BitRateSel <= detCode;
        end
    end

    // Status decode from the state register.
    always_comb begin
        busy   = (state == S_WAIT_IDLE) || (state == S_WAIT_FALL) || (state == S_MEASURE) ||
                 (state == S_CLASSIFY)  || (state == S_VERIFY);
        locked = (state == S_LOCK);
        error  = (state == S_FAIL);
    end

endmodule
